// File: rtl/ttt_pkg.sv
// ttt_pkg: shared constants, state types and character helpers for the
// tic-tac-toe UART renderer.
//   - ASCII constants for cells and line endings
//   - Row masks for the 9-bit board vector (bit 8 = top-right, bit 0 = bottom-left)
//   - FSM state enums for the byte serializer and the frame sequencer
//   - render_char(): byte for frame position idx (0..14)
// Optional feature macro: TTT_RENDER_CURSOR_EN
//   When defined, render_char() also takes the cursor vector and draws the
//   cursor cell as '_' (empty) or 'x' (occupied).
package ttt_pkg;

  localparam logic [7:0] CH_X     = 8'h58;
  localparam logic [7:0] CH_DOT   = 8'h2E;
  localparam logic [7:0] CH_UNDER = 8'h5F;
  localparam logic [7:0] CH_XLOW  = 8'h78;
  localparam logic [7:0] CH_CR    = 8'h0D;
  localparam logic [7:0] CH_LF    = 8'h0A;

  localparam logic [8:0] ROW0_MASK = 9'b111_000_000;
  localparam logic [8:0] ROW1_MASK = 9'b000_111_000;
  localparam logic [8:0] ROW2_MASK = 9'b000_000_111;

  localparam int unsigned FRAME_LEN = 15;
  localparam logic [3:0]  LAST_CHAR = 4'(FRAME_LEN - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } tx_state_t;

  typedef enum logic {
    TOP_IDLE  = 1'b0,
    TOP_FRAME = 1'b1
  } top_state_t;

  // Column of frame position idx; 3 marks a CR/LF position.
  function automatic logic [1:0] char_col(input logic [3:0] idx);
    logic [1:0] col;
    case (idx)
      4'd0, 4'd5, 4'd10: col = 2'd0;
      4'd1, 4'd6, 4'd11: col = 2'd1;
      4'd2, 4'd7, 4'd12: col = 2'd2;
      default:           col = 2'd3;
    endcase
    return col;
  endfunction

  // The three bits of the row that frame position idx belongs to, column 0 in bit 0.
  function automatic logic [2:0] row_bits(input logic [3:0] idx, input logic [8:0] vec);
    logic [8:0] masked;
    if (idx < 4'd5) begin
      masked = vec & ROW0_MASK;
    end else if (idx < 4'd10) begin
      masked = vec & ROW1_MASK;
    end else begin
      masked = vec & ROW2_MASK;
    end
    return masked[8:6] | masked[5:3] | masked[2:0];
  endfunction

  // Bit of vec for the cell at frame position idx (0 for CR/LF positions).
  function automatic logic cell_bit(input logic [3:0] idx, input logic [8:0] vec);
    logic [2:0] rb;
    logic       b;
    rb = row_bits(idx, vec);
    case (char_col(idx))
      2'd0:    b = rb[0];
      2'd1:    b = rb[1];
      2'd2:    b = rb[2];
      default: b = 1'b0;
    endcase
    return b;
  endfunction

  function automatic logic [7:0] eol_char(input logic [3:0] idx);
    logic [7:0] ch;
    case (idx)
      4'd3, 4'd8, 4'd13: ch = CH_CR;
      default:           ch = CH_LF;
    endcase
    return ch;
  endfunction

  function automatic logic [7:0] render_char(
    input logic [3:0] idx,
    input logic [8:0] occ_vec
`ifdef TTT_RENDER_CURSOR_EN
    , input logic [8:0] cur_vec
`endif
  );
    logic [7:0] ch;
    logic       occ;
    occ = cell_bit(idx, occ_vec);
    if (char_col(idx) == 2'd3) begin
      ch = eol_char(idx);
`ifdef TTT_RENDER_CURSOR_EN
    end else if (cell_bit(idx, cur_vec)) begin
      ch = occ ? CH_XLOW : CH_UNDER;
`endif
    end else if (occ) begin
      ch = CH_X;
    end else begin
      ch = CH_DOT;
    end
    return ch;
  endfunction

endpackage

// File: rtl/ttt_uart_tx.sv
// ttt_uart_tx: 8N1 byte serializer with valid/ready handshake.
//   clk, reset   : clock, asynchronous active-high reset
//   valid, data  : byte offered; taken on a cycle where ready is high
//   ready        : high in idle and on the last cycle of a stop bit, so a
//                  byte offered then starts its start bit with no gap
//   tx           : registered serial line, idle high
module ttt_uart_tx
  import ttt_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 868
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       valid,
  input  logic [7:0] data,
  output logic       ready,
  output logic       tx
);

  localparam int unsigned       BAUD_W    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);

  tx_state_t         state_r, state_nxt_s;
  logic [BAUD_W-1:0] baud_r, baud_nxt_s;
  logic [2:0]        bit_r, bit_nxt_s;
  logic [7:0]        shift_r, shift_nxt_s;
  logic              tx_r, tx_nxt_s;
  logic              baud_done_s;

  assign baud_done_s = (baud_r == BAUD_LAST);
  assign tx          = tx_r;

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic: each phase lasts one baud period; stop chains into start when a byte waits.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (valid) state_nxt_s = ST_START;
        else       state_nxt_s = ST_IDLE;
      end
      ST_START: begin
        if (baud_done_s) state_nxt_s = ST_DATA;
        else             state_nxt_s = ST_START;
      end
      ST_DATA: begin
        if (baud_done_s && (bit_r == 3'd7)) state_nxt_s = ST_STOP;
        else                                state_nxt_s = ST_DATA;
      end
      ST_STOP: begin
        if (baud_done_s) state_nxt_s = valid ? ST_START : ST_IDLE;
        else             state_nxt_s = ST_STOP;
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // Output/datapath logic: line level, baud counter, bit index, shift register, handshake.
  always_comb begin
    tx_nxt_s    = tx_r;
    baud_nxt_s  = baud_r;
    bit_nxt_s   = bit_r;
    shift_nxt_s = shift_r;
    ready       = 1'b0;
    case (state_r)
      ST_IDLE: begin
        ready      = 1'b1;
        baud_nxt_s = '0;
        bit_nxt_s  = 3'd0;
        if (valid) begin
          shift_nxt_s = data;
          tx_nxt_s    = 1'b0;
        end else begin
          tx_nxt_s    = 1'b1;
        end
      end
      ST_START: begin
        if (baud_done_s) begin
          baud_nxt_s = '0;
          bit_nxt_s  = 3'd0;
          tx_nxt_s   = shift_r[0];
        end else begin
          baud_nxt_s = baud_r + BAUD_W'(1'b1);
        end
      end
      ST_DATA: begin
        if (baud_done_s) begin
          baud_nxt_s = '0;
          if (bit_r == 3'd7) begin
            tx_nxt_s = 1'b1;
          end else begin
            // Shift so the next bit to send always sits at shift_r[0].
            bit_nxt_s   = bit_r + 3'd1;
            shift_nxt_s = {1'b0, shift_r[7:1]};
            tx_nxt_s    = shift_r[1];
          end
        end else begin
          baud_nxt_s = baud_r + BAUD_W'(1'b1);
        end
      end
      ST_STOP: begin
        if (baud_done_s) begin
          ready      = 1'b1;
          baud_nxt_s = '0;
          bit_nxt_s  = 3'd0;
          if (valid) begin
            shift_nxt_s = data;
            tx_nxt_s    = 1'b0;
          end else begin
            tx_nxt_s    = 1'b1;
          end
        end else begin
          baud_nxt_s = baud_r + BAUD_W'(1'b1);
        end
      end
      default: begin
        tx_nxt_s   = 1'b1;
        baud_nxt_s = '0;
        bit_nxt_s  = 3'd0;
      end
    endcase
  end

  // Datapath registers; line idles high out of reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tx_r    <= 1'b1;
      baud_r  <= '0;
      bit_r   <= 3'd0;
      shift_r <= 8'h00;
    end else begin
      tx_r    <= tx_nxt_s;
      baud_r  <= baud_nxt_s;
      bit_r   <= bit_nxt_s;
      shift_r <= shift_nxt_s;
    end
  end

endmodule

// File: rtl/ttt_uart_render.sv
// ttt_uart_render: renders the tic-tac-toe grid as a 15-byte ASCII picture
// (3 rows of 3 cells + CR LF) over an 8N1 UART line.
//   clk, reset   : clock, asynchronous active-high reset
//   board        : occupied cells (bit (2-r)*3+c for row r, column c)
//   cursor_pos   : one-hot cursor cell, used only with TTT_RENDER_CURSOR_EN
//   draw_trigger : render request, sampled every cycle
//   tx           : UART line, idle high
//   busy         : high while a frame is being sent
// Optional feature macro: TTT_RENDER_CURSOR_EN (cursor cell drawn as '_'/'x').
// Triggers seen during a frame collapse into one re-render that starts right
// after the final stop bit with a fresh snapshot of the inputs.
module ttt_uart_render
  import ttt_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 868
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [8:0] board,
  input  logic [8:0] cursor_pos,
  input  logic       draw_trigger,
  output logic       tx,
  output logic       busy
);

  top_state_t state_r, state_nxt_s;
  logic [8:0] board_r, cursor_r;
  logic [3:0] char_r, char_nxt_s;
  logic       pending_r, pending_nxt_s;
  logic       busy_r;
  logic       tx_ready_s, tx_valid_s, load_s, pend_eff_s, last_char_s;
  logic [8:0] board_sel_s;
  logic [7:0] char_byte_s;

  // A trigger in the very cycle the last stop bit ends still counts as pending.
  assign pend_eff_s  = pending_r | draw_trigger;
  assign last_char_s = (char_r == LAST_CHAR);
  assign busy        = busy_r;

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= TOP_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic: leave the frame only when the last byte ends with nothing pending.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      TOP_IDLE: begin
        if (draw_trigger) state_nxt_s = TOP_FRAME;
        else              state_nxt_s = TOP_IDLE;
      end
      TOP_FRAME: begin
        if (tx_ready_s && last_char_s && !pend_eff_s) state_nxt_s = TOP_IDLE;
        else                                          state_nxt_s = TOP_FRAME;
      end
      default: state_nxt_s = TOP_IDLE;
    endcase
  end

  // Output logic: byte handoff, snapshot load, char index and pending flag.
  always_comb begin
    load_s        = 1'b0;
    tx_valid_s    = 1'b0;
    char_nxt_s    = char_r;
    pending_nxt_s = pending_r;
    case (state_r)
      TOP_IDLE: begin
        if (draw_trigger) begin
          load_s     = 1'b1;
          tx_valid_s = 1'b1;
          char_nxt_s = 4'd0;
        end else begin
          char_nxt_s = char_r;
        end
      end
      TOP_FRAME: begin
        if (tx_ready_s && !last_char_s) begin
          tx_valid_s    = 1'b1;
          char_nxt_s    = char_r + 4'd1;
          pending_nxt_s = pend_eff_s;
        end else if (tx_ready_s && pend_eff_s) begin
          load_s        = 1'b1;
          tx_valid_s    = 1'b1;
          char_nxt_s    = 4'd0;
          pending_nxt_s = 1'b0;
        end else if (tx_ready_s) begin
          pending_nxt_s = 1'b0;
        end else begin
          pending_nxt_s = pend_eff_s;
        end
      end
      default: begin
        char_nxt_s    = 4'd0;
        pending_nxt_s = 1'b0;
      end
    endcase
  end

  // The byte handed over on a load cycle must come from the live inputs,
  // since the snapshot registers only update on that same edge.
  assign board_sel_s = load_s ? board : board_r;

`ifdef TTT_RENDER_CURSOR_EN
  logic [8:0] cursor_sel_s;
  assign cursor_sel_s = load_s ? cursor_pos : cursor_r;
  assign char_byte_s  = render_char(char_nxt_s, board_sel_s, cursor_sel_s);
`else
  logic unused_cursor_s;
  assign unused_cursor_s = ^cursor_r;
  assign char_byte_s     = render_char(char_nxt_s, board_sel_s);
`endif

  // Frame registers: snapshot, char index, pending flag, busy.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      board_r   <= 9'h000;
      cursor_r  <= 9'h000;
      char_r    <= 4'd0;
      pending_r <= 1'b0;
      busy_r    <= 1'b0;
    end else begin
      board_r   <= load_s ? board : board_r;
      cursor_r  <= load_s ? cursor_pos : cursor_r;
      char_r    <= char_nxt_s;
      pending_r <= pending_nxt_s;
      busy_r    <= (state_nxt_s == TOP_FRAME);
    end
  end

  ttt_uart_tx #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_tx (
    .clk   (clk),
    .reset (reset),
    .valid (tx_valid_s),
    .data  (char_byte_s),
    .ready (tx_ready_s),
    .tx    (tx)
  );

endmodule

// File: tb/tb_ttt_uart_render.sv
// tb_ttt_uart_render: directed self-checking bench for ttt_uart_render with
// CLKS_PER_BIT = 4. Inputs change on the falling edge; outputs are sampled on
// the falling edge. Honours TTT_RENDER_CURSOR_EN for the expected pictures.
module tb_ttt_uart_render;

  localparam int unsigned CPB  = 4;
  localparam logic [15:0] CRLF = 16'h0D0A;

  localparam logic [119:0] DOTS = {"...", CRLF, "...", CRLF, "...", CRLF};
  localparam logic [119:0] XS   = {"XXX", CRLF, "XXX", CRLF, "XXX", CRLF};
`ifdef TTT_RENDER_CURSOR_EN
  localparam logic [119:0] EXP1 = {".._", CRLF, "...", CRLF, "...", CRLF};
  localparam logic [119:0] EXP2 = {"...", CRLF, ".x.", CRLF, "X..", CRLF};
`else
  localparam logic [119:0] EXP1 = DOTS;
  localparam logic [119:0] EXP2 = {"...", CRLF, ".X.", CRLF, "X..", CRLF};
`endif
  // 0x2E on the line: start 0, bits 0,1,1,1,0,1,0,0, stop 1; 4 clocks each.
  localparam logic [39:0] WAVE_2E = 40'h00FFF0F00F;

  logic       clk = 1'b0;
  logic       reset;
  logic [8:0] board;
  logic [8:0] cursor_pos;
  logic       draw_trigger;
  logic       tx;
  logic       busy;

  int n_tests = 0;
  int n_fail  = 0;
  int busy_total = 0;

  ttt_uart_render #(
    .CLKS_PER_BIT(CPB)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .board        (board),
    .cursor_pos   (cursor_pos),
    .draw_trigger (draw_trigger),
    .tx           (tx),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (busy === 1'b1) busy_total <= busy_total + 1;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Called on a falling edge. Waits for a start bit, then samples each bit mid-cell.
  // With inject set, pulses draw_trigger three times and fills the board during the byte.
  task automatic rx_byte(input bit inject, output logic [8:0] val, output int waited);
    waited = 0;
    while (tx !== 1'b0 && waited < 400) begin
      @(negedge clk);
      waited++;
    end
    val = 9'h000;
    for (int n = 1; n <= 37; n++) begin
      @(negedge clk);
      if (inject) begin
        draw_trigger = (n == 1 || n == 3 || n == 6);
        if (n == 2) board = 9'h1FF;
      end
      if (n >= 5 && (n % 4) == 1) val[(n - 5) / 4] = tx;
    end
  endtask

  task automatic rx_frame(input string tag, input logic [119:0] exp, input int inject_at);
    logic [8:0] v;
    int w;
    for (int i = 0; i < 15; i++) begin
      rx_byte(i == inject_at, v, w);
      chk($sformatf("%s_byte%0d", tag, i), 64'(v), 64'({1'b1, exp[119 - 8*i -: 8]}));
    end
  endtask

  task automatic wait_idle(input string tag);
    int k;
    k = 0;
    while (busy !== 1'b0 && k < 2000) begin
      @(negedge clk);
      k++;
    end
    chk({tag, "_idle_wait"}, 64'(k < 2000), 64'd1);
  endtask

  task automatic quiet(input string tag, input int cycles);
    int bad;
    bad = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (tx !== 1'b1 || busy !== 1'b0) bad++;
    end
    chk(tag, 64'(bad), 64'd0);
  endtask

  initial begin
    logic [39:0] wave;
    logic [8:0]  v;
    int          w;
    int          b0;

    reset        = 1'b1;
    board        = 9'h000;
    cursor_pos   = 9'h000;
    draw_trigger = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_tx", 64'(tx), 64'd1);
    chk("reset_busy", 64'(busy), 64'd0);

    // No trigger: line stays idle.
    reset = 1'b0;
    quiet("idle_no_trigger", 100);

    // Trigger held through reset: frame starts on the first edge after release.
    reset        = 1'b1;
    draw_trigger = 1'b1;
    cursor_pos   = 9'b100_000_000;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    b0    = busy_total;
    @(negedge clk);
    draw_trigger = 1'b0;
    chk("release_tx_start", 64'(tx), 64'd0);
    chk("release_busy", 64'(busy), 64'd1);
    rx_frame("release", EXP1, -1);
    wait_idle("release");
    chk("release_busy_cycles", 64'(busy_total - b0), 64'd600);
    chk("release_tx_idle", 64'(tx), 64'd1);

    // Cell mapping.
    board      = 9'b000_010_001;
    cursor_pos = 9'b000_010_000;
    @(negedge clk);
    draw_trigger = 1'b1;
    @(negedge clk);
    draw_trigger = 1'b0;
    rx_frame("map", EXP2, -1);
    wait_idle("map");

    // Triggers and board change during byte 5: snapshot holds, one re-render follows.
    board      = 9'h000;
    cursor_pos = 9'h000;
    @(negedge clk);
    draw_trigger = 1'b1;
    @(negedge clk);
    draw_trigger = 1'b0;
    rx_frame("snapshot", DOTS, 5);
    repeat (3) @(negedge clk);
    chk("rerender_no_gap_tx", 64'(tx), 64'd0);
    chk("rerender_busy", 64'(busy), 64'd1);
    rx_frame("rerender", XS, -1);
    wait_idle("rerender");
    quiet("single_rerender", 100);

    // Bit-level waveform of the first byte '.'.
    board = 9'h000;
    @(negedge clk);
    draw_trigger = 1'b1;
    @(negedge clk);
    draw_trigger = 1'b0;
    for (int n = 0; n < 40; n++) begin
      wave[39 - n] = tx;
      if (n < 39) @(negedge clk);
    end
    chk("wave_byte0", 64'(wave), 64'(WAVE_2E));
    for (int i = 1; i < 7; i++) begin
      rx_byte(1'b0, v, w);
      chk($sformatf("pre_reset_byte%0d", i), 64'(v), 64'({1'b1, DOTS[119 - 8*i -: 8]}));
    end

    // Reset in the middle of data bit 0 of byte 7.
    w = 0;
    while (tx !== 1'b0 && w < 400) begin
      @(negedge clk);
      w++;
    end
    repeat (5) @(negedge clk);
    chk("byte7_bit0_low", 64'(tx), 64'd0);
    #2 reset = 1'b1;
    #1;
    chk("midframe_reset_tx", 64'(tx), 64'd1);
    chk("midframe_reset_busy", 64'(busy), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    quiet("after_reset_idle", 200);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
